// File: rtl/system_ocm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : system_ocm_arbiter_if
// Brief    : Avalon-MM master-side bundle for one shared-memory requester.
// Revision : 1.0 - initial release
// ============================================================================
interface system_ocm_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              lock;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, read, write, byteenable, writedata, lock,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, byteenable, writedata, lock,
        output waitrequest, readdata
    );
endinterface
`default_nettype wire

// File: rtl/system_ocm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : system_ocm_arbiter
// Brief    : Round-robin two-master arbiter for on-chip memory port s1 with
//            lock support and a lock-timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module system_ocm_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 32,
    parameter int BE_W         = 4,
    parameter int LOCK_TIMEOUT = 64
) (
    input  wire                clk,
    input  wire                reset_n,
    system_ocm_arbiter_if.slave m0,
    system_ocm_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_chipselect,
    output logic               mem_write,
    output logic [BE_W-1:0]    mem_byteenable,
    output logic [DATA_W-1:0]  mem_writedata,
    output logic               mem_clken,
    input  wire  [DATA_W-1:0]  mem_readdata,
    output logic               lock_timeout_err
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_DATA = 1'b1
    } state_t;

    localparam logic [7:0] c_wait_limit = 8'(LOCK_TIMEOUT - 1);

    state_t     r_state;
    logic       r_gnt_idx;
    logic       r_last;
    logic       r_lock_valid;
    logic       r_lock_owner;
    logic [7:0] r_wait_cnt;
    logic       r_lock_timeout_err;

    logic w_req0, w_req1;
    logic w_cand0, w_cand1;
    logic w_win, w_win_wr, w_sel;
    logic w_grant, w_wr_grant, w_rd_grant, w_rd_done;
    logic w_done0, w_done1;
    logic w_nonowner_req;

    // Grants are gated by reset so nothing reaches the memory while it is held.
    always_comb begin
        w_req0         = m0.read | m0.write;
        w_req1         = m1.read | m1.write;
        w_cand0        = w_req0 & (~r_lock_valid | ~r_lock_owner);
        w_cand1        = w_req1 & (~r_lock_valid |  r_lock_owner);
        w_win          = (w_cand0 & w_cand1) ? ~r_last : ~w_cand0;
        w_grant        = reset_n & (r_state == ST_IDLE) & (w_cand0 | w_cand1);
        w_win_wr       = w_win ? m1.write : m0.write;
        w_wr_grant     = w_grant & w_win_wr;
        w_rd_grant     = w_grant & ~w_win_wr;
        w_rd_done      = reset_n & (r_state == ST_RD_DATA);
        w_done0        = (w_wr_grant & ~w_win) | (w_rd_done & ~r_gnt_idx);
        w_done1        = (w_wr_grant &  w_win) | (w_rd_done &  r_gnt_idx);
        w_sel          = (r_state == ST_IDLE) ? w_win : r_gnt_idx;
        w_nonowner_req = r_lock_owner ? w_req0 : w_req1;

        mem_address    = w_sel ? m1.address    : m0.address;
        mem_byteenable = w_sel ? m1.byteenable : m0.byteenable;
        mem_writedata  = w_sel ? m1.writedata  : m0.writedata;
        mem_chipselect = w_grant;
        mem_write      = w_wr_grant;
    end

    assign mem_clken        = 1'b1;
    assign m0.waitrequest   = ~w_done0;
    assign m1.waitrequest   = ~w_done1;
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign lock_timeout_err = r_lock_timeout_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= ST_IDLE;
            r_gnt_idx          <= 1'b0;
            r_last             <= 1'b1;
            r_lock_valid       <= 1'b0;
            r_lock_owner       <= 1'b0;
            r_wait_cnt         <= 8'd0;
            r_lock_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_grant) begin
                        r_gnt_idx <= w_win;
                        r_state   <= ST_RD_DATA;
                    end
                    if (w_wr_grant) begin
                        r_last <= w_win;
                    end
                end
                ST_RD_DATA: begin
                    r_last  <= r_gnt_idx;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_done0) begin
                if (m0.lock) begin
                    r_lock_valid <= 1'b1;
                    r_lock_owner <= 1'b0;
                end else if (!r_lock_owner) begin
                    r_lock_valid <= 1'b0;
                end
            end
            if (w_done1) begin
                if (m1.lock) begin
                    r_lock_valid <= 1'b1;
                    r_lock_owner <= 1'b1;
                end else if (r_lock_owner) begin
                    r_lock_valid <= 1'b0;
                end
            end

            // Watchdog release overrides any lock update; held at the limit during a read.
            if (r_lock_valid && w_nonowner_req) begin
                if (r_wait_cnt >= c_wait_limit) begin
                    if (r_state == ST_IDLE) begin
                        r_lock_valid       <= 1'b0;
                        r_lock_timeout_err <= 1'b1;
                        r_wait_cnt         <= 8'd0;
                    end
                end else begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end else begin
                r_wait_cnt <= 8'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_system_ocm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_system_ocm_arbiter
// Brief    : Directed self-checking bench for system_ocm_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_system_ocm_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int LT     = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    system_ocm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) if_m0 ();
    system_ocm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) if_m1 ();

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [BE_W-1:0]   mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic              lock_timeout_err;

    system_ocm_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0               (if_m0),
        .m1               (if_m1),
        .mem_address      (mem_address),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .lock_timeout_err (lock_timeout_err)
    );

    // On-chip memory: registered address, unregistered q.
    logic [DATA_W-1:0] mem_arr [2**ADDR_W];
    logic [ADDR_W-1:0] mem_addr_q;
    always @(posedge clk) begin
        if (mem_clken) begin
            mem_addr_q <= mem_address;
            if (mem_chipselect && mem_write)
                for (int b = 0; b < BE_W; b++)
                    if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
    end
    assign mem_readdata = mem_arr[mem_addr_q];

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] sb_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_read(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        chk({tag, "_pending"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic drv(input int k, input logic rd, input logic wr, input logic [6:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic lk);
        if (k == 0) begin
            if_m0.read = rd; if_m0.write = wr; if_m0.address = a;
            if_m0.writedata = d; if_m0.byteenable = be; if_m0.lock = lk;
        end else begin
            if_m1.read = rd; if_m1.write = wr; if_m1.address = a;
            if_m1.writedata = d; if_m1.byteenable = be; if_m1.lock = lk;
        end
    endtask

    task automatic quiet(input int k);
        drv(k, 1'b0, 1'b0, 7'h00, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        quiet(0);
        quiet(1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset / idle
        @(negedge clk);
        chk("rst_m0_wait", if_m0.waitrequest, 1);
        chk("rst_m1_wait", if_m1.waitrequest, 1);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_we", mem_write, 0);
        chk("rst_clken", mem_clken, 1);
        chk("rst_err", lock_timeout_err, 0);
        next();

        // Single write then read of the same word
        drv(0, 0, 1, 7'h05, 32'hDEADBEEF, 4'hF, 0);
        @(negedge clk);
        chk("wr_m0_wait", if_m0.waitrequest, 0);
        chk("wr_m1_wait", if_m1.waitrequest, 1);
        chk("wr_cs", mem_chipselect, 1);
        chk("wr_we", mem_write, 1);
        chk("wr_addr", mem_address, 7'h05);
        chk("wr_data", mem_writedata, 32'hDEADBEEF);
        chk("wr_be", mem_byteenable, 4'hF);
        next();
        drv(0, 1, 0, 7'h05, 32'h0, 4'hF, 0);
        sb_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("rd_issue_wait", if_m0.waitrequest, 1);
        chk("rd_issue_cs", mem_chipselect, 1);
        chk("rd_issue_we", mem_write, 0);
        next();
        @(negedge clk);
        chk("rd_done_wait", if_m0.waitrequest, 0);
        chk("rd_done_cs", mem_chipselect, 0);
        chk_read("rd_data", if_m0.readdata);
        next();
        quiet(0);

        // Byte lanes
        drv(0, 0, 1, 7'h20, 32'hFFFFFFFF, 4'hF, 0);
        @(negedge clk);
        chk("be_wr1_wait", if_m0.waitrequest, 0);
        next();
        drv(0, 0, 1, 7'h20, 32'h00000000, 4'h3, 0);
        @(negedge clk);
        chk("be_wr2_wait", if_m0.waitrequest, 0);
        chk("be_wr2_be", mem_byteenable, 4'h3);
        next();
        drv(0, 1, 0, 7'h20, 32'h0, 4'hF, 0);
        sb_q.push_back(32'hFFFF0000);
        @(negedge clk);
        chk("be_rd_issue_wait", if_m0.waitrequest, 1);
        next();
        @(negedge clk);
        chk("be_rd_done_wait", if_m0.waitrequest, 0);
        chk_read("be_rd_data", if_m0.readdata);
        next();
        quiet(0);

        // Read then write to the same word: the read sees old data
        drv(1, 1, 0, 7'h05, 32'h0, 4'hF, 0);
        drv(0, 0, 1, 7'h05, 32'hCAFEF00D, 4'hF, 0);
        sb_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("rw_m1_issue_wait", if_m1.waitrequest, 1);
        chk("rw_m0_blocked", if_m0.waitrequest, 1);
        chk("rw_cs", mem_chipselect, 1);
        chk("rw_we", mem_write, 0);
        next();
        @(negedge clk);
        chk("rw_m1_done_wait", if_m1.waitrequest, 0);
        chk("rw_m0_still_wait", if_m0.waitrequest, 1);
        chk_read("rw_m1_data", if_m1.readdata);
        next();
        quiet(1);
        @(negedge clk);
        chk("rw_m0_wr_wait", if_m0.waitrequest, 0);
        chk("rw_m0_wr_we", mem_write, 1);
        next();
        drv(0, 1, 0, 7'h05, 32'h0, 4'hF, 0);
        sb_q.push_back(32'hCAFEF00D);
        next();
        @(negedge clk);
        chk("rw_rd_new_wait", if_m0.waitrequest, 0);
        chk_read("rw_rd_new_data", if_m0.readdata);
        next();
        quiet(0);

        // Lock: m1 locked read then unlocking write while m0 keeps asking
        drv(0, 0, 1, 7'h30, 32'h11111111, 4'hF, 0);
        drv(1, 1, 0, 7'h05, 32'h0, 4'hF, 1);
        sb_q.push_back(32'hCAFEF00D);
        @(negedge clk);
        chk("lk_rd_m1_wait", if_m1.waitrequest, 1);
        chk("lk_rd_m0_wait", if_m0.waitrequest, 1);
        next();
        @(negedge clk);
        chk("lk_rd_done", if_m1.waitrequest, 0);
        chk("lk_rd_m0_wait2", if_m0.waitrequest, 1);
        chk_read("lk_rd_data", if_m1.readdata);
        next();
        drv(1, 0, 1, 7'h31, 32'h00000055, 4'hF, 0);
        @(negedge clk);
        chk("lk_wr_m1_wait", if_m1.waitrequest, 0);
        chk("lk_wr_m0_wait", if_m0.waitrequest, 1);
        chk("lk_wr_addr", mem_address, 7'h31);
        next();
        quiet(1);
        @(negedge clk);
        chk("lk_m0_grant", if_m0.waitrequest, 0);
        chk("lk_m0_addr", mem_address, 7'h30);
        next();
        quiet(0);

        // Reset during RD_DATA drops the read
        drv(0, 1, 0, 7'h05, 32'h0, 4'hF, 0);
        @(negedge clk);
        chk("mr_issue_wait", if_m0.waitrequest, 1);
        next();
        reset_n = 1'b0;
        #1;
        chk("mr_m0_wait", if_m0.waitrequest, 1);
        chk("mr_m1_wait", if_m1.waitrequest, 1);
        chk("mr_cs", mem_chipselect, 0);
        quiet(0);
        next();
        reset_n = 1'b1;

        // Contention after reset: strict alternation starting with m0
        drv(0, 0, 1, 7'h10, 32'h000000A0, 4'hF, 0);
        drv(1, 0, 1, 7'h11, 32'h000000B1, 4'hF, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("ct%0d_m0_wait", i), if_m0.waitrequest, 32'(i % 2));
            chk($sformatf("ct%0d_m1_wait", i), if_m1.waitrequest, 32'(1 - (i % 2)));
            chk($sformatf("ct%0d_addr", i), mem_address, 32'(7'h10 + 7'(i % 2)));
            next();
        end
        quiet(0);
        quiet(1);

        // Lock timeout: m0 locks and walks away, m1 keeps requesting
        drv(0, 0, 1, 7'h40, 32'h00000077, 4'hF, 1);
        @(negedge clk);
        chk("to_lock_wr", if_m0.waitrequest, 0);
        next();
        quiet(0);
        drv(1, 0, 1, 7'h41, 32'h00000088, 4'hF, 0);
        for (int i = 1; i <= LT; i++) begin
            @(negedge clk);
            chk($sformatf("to_c%0d_m1_wait", i), if_m1.waitrequest, 1);
            chk($sformatf("to_c%0d_err", i), lock_timeout_err, 0);
            next();
        end
        @(negedge clk);
        chk("to_err_set", lock_timeout_err, 1);
        chk("to_m1_grant", if_m1.waitrequest, 0);
        chk("to_m1_addr", mem_address, 7'h41);
        next();
        quiet(1);
        @(negedge clk);
        chk("to_err_sticky", lock_timeout_err, 1);
        next();

        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/system_ocm_arbiter.md
# system_ocm_arbiter

Two-master arbiter that shares port s1 of the 128 x 32 shared on-chip memory between two Avalon-MM masters, such as two processor data masters. It serialises accesses with round-robin fairness and an optional lock for atomic read-modify-write sequences. A lock-timeout watchdog stops a stuck master from starving the other one. It sits between the two masters and the memory's s1 port. Port s2 is not touched.

## Interface
Parameters:
- ADDR_W, 7, word address width (128 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width
- LOCK_TIMEOUT, 64, number of cycles the non-owner may wait on a held lock before it is force-released; range 1..255

Ports:
- clk  in  1  single clock for everything
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  master word address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_lock / m1_lock  in  1  keep the grant after this transaction completes
- m0_waitrequest / m1_waitrequest  out  1  Avalon waitrequest
- m0_readdata / m1_readdata  out  DATA_W  read data, valid on a read's completion cycle
- mem_address  out  ADDR_W  to s1
- mem_chipselect  out  1  to s1
- mem_write  out  1  to s1
- mem_byteenable  out  BE_W  to s1
- mem_writedata  out  DATA_W  to s1
- mem_clken  out  1  to s1; tied to 1
- mem_readdata  in  DATA_W  from s1; address is registered inside the memory, q is unregistered
- lock_timeout_err  out  1  sticky flag; set when a lock is force-released

## Operation
- Request: req_k = mk_read | mk_write. mk_read and mk_write both high counts as a write.
- State machine:
  - IDLE: issues transactions.
  - RD_DATA: completes a read.
- Registers:
  - state
  - gnt_idx: master owning the current read
  - last: master served most recently
  - lock_valid and lock_owner
  - wait_cnt: 8 bits
  - lock_timeout_err
- Eligibility in IDLE:
  - No lock held: either requester is eligible.
  - Lock held: only lock_owner is eligible.
- Selection: if both masters are eligible and requesting, the one that is not `last` wins. Otherwise the single eligible requester wins.
- Granted write in IDLE:
  - mem_chipselect=1, mem_write=1.
  - address, byteenable and writedata pass through combinationally from the winner.
  - mk_waitrequest=0 in the same cycle; the transaction completes in that cycle.
  - last <= k. State stays IDLE.
- Granted read in IDLE:
  - mem_chipselect=1, mem_write=0, address from the winner.
  - mk_waitrequest=1.
  - gnt_idx <= k, state <= RD_DATA.
- RD_DATA:
  - mk_waitrequest=0 for gnt_idx; the read completes in this cycle.
  - mem_chipselect=0.
  - last <= gnt_idx, state <= IDLE.
  - The master holds its address per Avalon rules.
- m0_readdata and m1_readdata both equal mem_readdata at all times. The data is only meaningful on a read's completion cycle.
- mk_waitrequest is 1 in every cycle where master k is not completing, whether or not it is requesting.
- Lock update, on each completion by master k:
  - mk_lock=1: lock_valid <= 1, lock_owner <= k.
  - mk_lock=0 and lock_owner==k: lock_valid <= 0.
- Lock watchdog:
  - wait_cnt increments each cycle in which lock_valid=1 and the non-owner is requesting. Otherwise it clears to 0.
  - When wait_cnt reaches LOCK_TIMEOUT-1 and the non-owner is still requesting: lock_valid <= 0, lock_timeout_err <= 1, wait_cnt <= 0.
  - The lock is not force-released in RD_DATA; the release is deferred until the next IDLE cycle.
- lock_timeout_err is cleared only by reset.
- No grant is issued from RD_DATA, so reads have no issue overlap.

## Timing
- Reset values:
  - state=IDLE, last=1 (so m0 wins the first tie), gnt_idx=0
  - lock_valid=0, lock_owner=0, wait_cnt=0, lock_timeout_err=0
  - both waitrequests=1, mem_chipselect=0, mem_write=0, mem_clken=1
- Reset asserted mid-read: the state returns to IDLE immediately and the pending read is dropped; its master sees waitrequest=1.
- Write latency: 0 wait cycles. Maximum throughput is 1 write per cycle per granted master.
- Read latency: exactly 1 wait cycle, so a read takes 2 cycles. Maximum throughput is 1 read per 2 cycles.
- Mixed accesses to the same address:
  - Write then read on the next cycle: returns the new data.
  - Read then write: the read returns the old data.
- Fairness under contention:
  - Equal-type requests alternate strictly.
  - A waiting master is served within 2 transactions unless a lock is held.
  - With a lock held, the non-owner is served within LOCK_TIMEOUT+2 cycles.

## Test plan
- Reset and idle: hold reset_n=0 for 3 cycles, then release with no requests -> both waitrequests=1, mem_chipselect=0, lock_timeout_err=0.
- Single access:
  - m0 writes 0xDEADBEEF to addr 0x05 with BE=0xF -> m0_waitrequest=0 in the same cycle.
  - m0 then reads addr 0x05 -> waitrequest=1 for 1 cycle, then 0 with m0_readdata=0xDEADBEEF.
- Contention: m0 and m1 both hold continuous writes to addr 0x10 and 0x11 -> grants alternate m0, m1, m0, m1, starting with m0 after reset.
- Byte lanes: write 0xFFFFFFFF, then write 0x00000000 with BE=0x3, then read -> 0xFFFF0000.
- Lock: m1 performs a read with m1_lock=1, then a write with m1_lock=0, while m0 requests the whole time -> m0 is not granted until the cycle after m1's unlocking write completes.
- Lock timeout: LOCK_TIMEOUT=8. m0 completes a locked access, then stops requesting, while m1 keeps requesting -> after 8 cycles lock_timeout_err=1 and m1 is granted on the next IDLE cycle.
